// File: rtl/bias_and_quantize.sv
// Post-accumulator output stage: adds a pre-scaled per-channel bias, applies ReLU,
// then rescales to an unsigned byte with round-half-up and saturation, registered.
module bias_and_quantize #(
  parameter int IN_W  = 18,
  parameter int B_W   = 8,
  parameter int OUT_W = 8,
  parameter int SHIFT = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  dout_relu,
  input  logic signed [B_W-1:0]   bias,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        dout
);

  // Handshake: in_valid qualifies dout_relu/bias for one edge; there is no ready,
  // every cycle is accepted. out_valid pulses for exactly the cycle after an accepted
  // input, and dout holds its last value whenever out_valid is low (except after rst).

  localparam int INT_W = IN_W + 2;
  localparam logic [INT_W-1:0] HALF  = INT_W'(1) << (SHIFT - 1);
  localparam logic [INT_W-1:0] Q_MAX = INT_W'((1 << OUT_W) - 1);

  logic signed [INT_W-1:0] bias_ext;
  logic signed [INT_W-1:0] acc_ext;
  logic signed [INT_W-1:0] b_s;
  logic signed [INT_W-1:0] sum;
  logic [INT_W-1:0]        r;
  logic [INT_W-1:0]        r_rnd;
  logic [INT_W-1:0]        q_full;
  logic [OUT_W-1:0]        dout_next;

  assign bias_ext = {{(INT_W - B_W){bias[B_W-1]}}, bias};
  assign acc_ext  = {{(INT_W - IN_W){dout_relu[IN_W-1]}}, dout_relu};
  assign b_s      = bias_ext <<< SHIFT;
  assign sum      = acc_ext + b_s;

  // r is non-negative after ReLU, so the rescale is a plain logical shift.
  assign r         = sum[INT_W-1] ? '0 : sum;
  assign r_rnd     = r + HALF;
  assign q_full    = r_rnd >> SHIFT;
  assign dout_next = (q_full > Q_MAX) ? '1 : q_full[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        dout <= dout_next;
      end
    end
  end

endmodule

// File: tb/tb_bias_and_quantize.sv
// Directed bench for bias_and_quantize: reset, sweeps, saturation, small values,
// negative floor and valid gating, with hand-computed expectations.
module tb_bias_and_quantize;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [17:0] dout_relu;
  logic signed [7:0]  bias;
  logic               out_valid;
  logic [7:0]         dout;

  int n_checks = 0;
  int n_pass   = 0;

  bias_and_quantize dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .dout_relu (dout_relu),
    .bias      (bias),
    .out_valid (out_valid),
    .dout      (dout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one cycle of inputs, then sample #1 after the edge that captures them.
  task automatic apply(input logic v, input logic signed [17:0] d, input logic signed [7:0] b);
    in_valid  = v;
    dout_relu = d;
    bias      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d);
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, "_dout"}, {24'd0, dout}, {24'd0, d});
  endtask

  logic [7:0] prev;

  initial begin
    rst = 1'b1; in_valid = 1'b0; dout_relu = '0; bias = '0;

    // reset held two cycles with a valid max input
    apply(1'b1, 18'sd131071, 8'sd0);
    expect_out("reset0", 1'b0, 8'd0);
    apply(1'b1, 18'sd131071, 8'sd0);
    expect_out("reset1", 1'b0, 8'd0);
    rst = 1'b0;
    apply(1'b1, 18'sd131071, 8'sd0);
    expect_out("first_after_reset", 1'b1, 8'd255);

    // mid-range sweep, dout_relu = 65536
    prev = 8'd0;
    for (int b = -128; b <= 127; b++) begin
      apply(1'b1, 18'sd65536, 8'(b));
      check("sweep_valid", {31'd0, out_valid}, 32'd1);
      check("sweep_mono", {31'd0, (dout >= prev)}, 32'd1);
      if (b == -128) check("sweep_b_m128", {24'd0, dout}, 32'd0);
      if (b == 0)    check("sweep_b_0", {24'd0, dout}, 32'd128);
      if (b == 127)  check("sweep_b_127", {24'd0, dout}, 32'd255);
      prev = dout;
    end

    // saturation
    apply(1'b1, 18'sd131071, 8'sd0);    expect_out("sat_b0", 1'b1, 8'd255);
    apply(1'b1, 18'sd131071, 8'sd127);  expect_out("sat_b127", 1'b1, 8'd255);
    apply(1'b1, 18'sd131071, -8'sd128); expect_out("sat_bm128", 1'b1, 8'd128);

    // zero and small values
    apply(1'b1, 18'sd0, -8'sd1);  expect_out("zero_bm1", 1'b1, 8'd0);
    apply(1'b1, 18'sd0, 8'sd5);   expect_out("zero_b5", 1'b1, 8'd5);
    apply(1'b1, 18'sd0, 8'sd127); expect_out("zero_b127", 1'b1, 8'd127);
    apply(1'b1, 18'sd1, 8'sd0);   expect_out("one_b0", 1'b1, 8'd0);
    apply(1'b1, -18'sd1, 8'sd1);  expect_out("m1_b1", 1'b1, 8'd1);
    apply(1'b1, 18'sd255, 8'sd0); expect_out("sum255", 1'b1, 8'd0);
    apply(1'b1, 18'sd256, 8'sd0); expect_out("sum256", 1'b1, 8'd1);

    // negative floor
    for (int b = -128; b <= 127; b++) begin
      apply(1'b1, -18'sd131072, 8'(b));
      check("floor_valid", {31'd0, out_valid}, 32'd1);
      check("floor_dout", {24'd0, dout}, 32'd0);
    end

    // valid gating
    apply(1'b1, 18'sd0, 8'sd127);   expect_out("gate_v1a", 1'b1, 8'd127);
    apply(1'b0, -18'sd1, 8'sd1);    expect_out("gate_v0a", 1'b0, 8'd127);
    apply(1'b1, -18'sd1, 8'sd1);    expect_out("gate_v1b", 1'b1, 8'd1);
    apply(1'b0, 18'sd131071, 8'sd0); expect_out("gate_v0b", 1'b0, 8'd1);
    apply(1'b1, 18'sd0, 8'sd5);     expect_out("gate_v1c", 1'b1, 8'd5);

    // reset mid-stream discards the in-flight result
    apply(1'b1, 18'sd131071, 8'sd0); expect_out("pre_midrst", 1'b1, 8'd255);
    rst = 1'b1;
    apply(1'b1, 18'sd0, 8'sd127);    expect_out("midrst", 1'b0, 8'd0);
    rst = 1'b0;
    apply(1'b0, 18'sd0, 8'sd127);    expect_out("post_midrst_idle", 1'b0, 8'd0);
    apply(1'b1, 18'sd0, 8'sd127);    expect_out("post_midrst", 1'b1, 8'd127);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bias_and_quantize.md
Name: bias_and_quantize

Overview:
Post-accumulator output stage of the neural-network datapath.
- Takes a signed 18-bit accumulator value (`dout_relu`) and a signed 8-bit per-channel bias.
- Adds the bias, scaled to accumulator LSBs, then applies ReLU.
- Rescales to 8 bits with round-half-up and unsigned saturation.
- Registers the result together with a valid flag; feeds the activation memory/output bus.

Parameters:
- IN_W, 18, accumulator input width (signed two's complement).
- B_W, 8, bias width (signed two's complement).
- OUT_W, 8, output width (unsigned).
- SHIFT, 9, right-shift from accumulator scale to output scale; bias is pre-scaled by the same amount.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  `dout_relu`/`bias` pair is valid this cycle.
- dout_relu  input  IN_W  signed accumulator value; may be negative.
- bias  input  B_W  signed bias in output-LSB units.
- out_valid  output  1  `dout` holds a new result.
- dout  output  OUT_W  unsigned quantized activation.

Behaviour:
- Reset: on a rising edge with `rst`=1, `dout`=0 and `out_valid`=0. `rst` has priority over `in_valid`.
- Latency: exactly 1 cycle. When `in_valid`=1 at edge N, `out_valid`=1 and `dout` holds the result after edge N.
- When `in_valid`=0 at an edge: `out_valid`=0 and `dout` holds its previous value. No back-pressure; a new input is accepted every cycle.
- Arithmetic, all signed, with internal width IN_W+2 (20 bits) so no intermediate overflow:
  - `b_s` = sign-extend(`bias`) <<< SHIFT (`bias` × 512).
  - `sum` = sign-extend(`dout_relu`) + `b_s`. Range is -196608..196095.
  - ReLU: if `sum` < 0 then `r` = 0, else `r` = `sum`.
  - Round half up: `q` = (`r` + 2^(SHIFT-1)) >> SHIFT, a logical shift since `r` ≥ 0.
  - Saturate: if `q` > 2^OUT_W − 1 then `dout` = 255, else `dout` = `q`[OUT_W-1:0].
- Boundary cases:
  - `sum` = 0 gives 0.
  - `sum` = 255 gives 0 (255+256=511, 511>>9=0).
  - `sum` = 256 gives 1 (exact half rounds up).
  - Max input with non-negative bias saturates at 255.
  - Min input (-131072) with any bias gives 0.
  - `bias` = -128 subtracts exactly 65536.
- Purely combinational from the input to the register D-input; the only state is the `dout` and `out_valid` registers.
- If `rst` is asserted mid-stream, the in-flight result is discarded: the next cycle shows `out_valid`=0 and `dout`=0.

Test Plan:
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1, `dout_relu`=131071 → `out_valid`=0 and `dout`=0 throughout. Release `rst` → first valid result appears one cycle later.
- Mid-range sweep, `dout_relu`=65536, `bias` swept -128..127 with `in_valid`=1 each cycle:
  - `bias`=-128 → 0; `bias`=0 → 128; `bias`=127 → 255.
  - Output is monotonically non-decreasing across the sweep, each result 1 cycle after its input.
- Saturation, `dout_relu`=131071:
  - `bias`=0 → 255 (q=256 clipped); `bias`=127 → 255.
  - `bias`=-128 → 128 (65535+256=65791, >>9 = 128).
- Zero and small values:
  - `dout_relu`=0: `bias`=-1 → 0; `bias`=5 → 5; `bias`=127 → 127.
  - `dout_relu`=1, `bias`=0 → 0.
  - `dout_relu`=-1, `bias`=1 → 1 (511 rounds up).
- Negative floor, `dout_relu`=-131072, full `bias` sweep → `dout`=0 for every `bias`, including 127 (sum=-66048).
- Valid gating: alternate `in_valid`=1/0 with changing inputs → `out_valid` toggles one cycle delayed, and `dout` is unchanged on cycles following `in_valid`=0.
